// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : IF-stage dynamic branch predictor. Direct-mapped BTB with a
//                2-bit saturating direction counter per entry. It is trained
//                by the ID-stage branch resolution. It flags mispredictions,
//                supplies the recovery PC and keeps saturating statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      IF_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ID_branch,
    input  logic [31:0]      ID_pc,
    input  logic             ID_taken,
    input  logic [31:0]      ID_target,
    input  logic             ID_pred_taken,
    input  logic [31:0]      ID_pred_tgt,
    output logic             mispredict,
    output logic [31:0]      recover_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int               ENTRIES = 1 << IDX_W;
    localparam logic [1:0]       SNT     = 2'b00;
    localparam logic [1:0]       WNT     = 2'b01;
    localparam logic [1:0]       WT      = 2'b10;
    localparam logic [1:0]       ST      = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];

    logic [CNT_W-1:0]   br_count_q,  br_count_d;
    logic [CNT_W-1:0]   miss_count_q, miss_count_d;

    // ---------------- Lookup ----------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic             unused_if_pc_bits;

    assign if_idx            = IF_pc[IDX_W+1:2];
    assign if_tag            = IF_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_if_pc_bits = ^{IF_pc[31:IDX_W+TAG_W+2], IF_pc[1:0]};
    assign if_hit            = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken        = if_hit && ctr_q[if_idx][1];
    assign pred_target       = if_hit ? tgt_q[if_idx] : 32'd0;

    // ---------------- Resolve ----------------
    // Reset gates the update so mispredict and training are quiet while rst is high.
    logic upd;
    assign upd        = ID_branch && !stall && !rst;
    assign mispredict = upd && ((ID_taken != ID_pred_taken) ||
                                (ID_taken && (ID_target != ID_pred_tgt)));
    assign recover_pc = ID_branch ? (ID_taken ? ID_target : ID_pc + 32'd4) : 32'd0;

    // ---------------- Training ----------------
    logic [IDX_W-1:0] id_idx;
    logic [TAG_W-1:0] id_tag;
    logic             id_hit;
    logic             ent_we;
    logic [1:0]       ctr_d;
    logic [31:0]      tgt_d;

    assign id_idx = ID_pc[IDX_W+1:2];
    assign id_tag = ID_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

    // Next-state of the entry addressed by ID_pc: counter step on hit, allocate on taken miss
    always_comb begin
        ent_we = 1'b0;
        ctr_d  = ctr_q[id_idx];
        tgt_d  = tgt_q[id_idx];
        if (upd) begin
            if (id_hit) begin
                ent_we = 1'b1;
                if (ID_taken) begin
                    ctr_d = (ctr_q[id_idx] == ST) ? ST : ctr_q[id_idx] + 2'd1;
                    tgt_d = ID_target;
                end else begin
                    ctr_d = (ctr_q[id_idx] == SNT) ? SNT : ctr_q[id_idx] - 2'd1;
                end
            end else if (ID_taken) begin
                ent_we = 1'b1;
                ctr_d  = WT;
                tgt_d  = ID_target;
            end
        end
    end

    // BTB storage; written after the edge so a same-cycle lookup sees the old entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (ent_we) begin
            valid_q[id_idx] <= 1'b1;
            ctr_q[id_idx]   <= ctr_d;
            tag_q[id_idx]   <= id_tag;
            tgt_q[id_idx]   <= tgt_d;
        end
    end

    // ---------------- Statistics ----------------
    // Saturating increments of the resolved-branch and misprediction counters
    always_comb begin
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (upd && (br_count_q != CNT_MAX)) begin
            br_count_d = br_count_q + 1'b1;
        end
        if (mispredict && (miss_count_q != CNT_MAX)) begin
            miss_count_d = miss_count_q + 1'b1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign br_count   = br_count_q;
    assign miss_count = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Self-checking bench for branch_predictor with a behavioural
//                BTB model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int NENT = 16;
    localparam int NTAG = 256;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic [31:0]   IF_pc;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          ID_branch;
    logic [31:0]   ID_pc;
    logic          ID_taken;
    logic [31:0]   ID_target;
    logic          ID_pred_taken;
    logic [31:0]   ID_pred_tgt;
    logic          mispredict;
    logic [31:0]   recover_pc;
    logic [CW-1:0] br_count;
    logic [CW-1:0] miss_count;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.IDX_W(4), .TAG_W(8), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .IF_pc(IF_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ID_branch(ID_branch), .ID_pc(ID_pc), .ID_taken(ID_taken),
        .ID_target(ID_target), .ID_pred_taken(ID_pred_taken),
        .ID_pred_tgt(ID_pred_tgt), .mispredict(mispredict),
        .recover_pc(recover_pc), .br_count(br_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model ----------------
    bit          m_valid [NENT];
    int          m_ctr   [NENT];
    int          m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_br, m_miss;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction
    function automatic int mtag(input logic [31:0] pc);
        return int'((pc >> 6) % NTAG);
    endfunction
    function automatic bit m_mis();
        return !rst && ID_branch && !stall &&
               ((ID_taken != ID_pred_taken) || (ID_taken && ID_target != ID_pred_tgt));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) begin
                m_valid[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_tgt[i] = 0;
            end
            m_br = 0; m_miss = 0;
        end else if (ID_branch && !stall) begin
            int i;
            i = midx(ID_pc);
            if (m_mis()) m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
            m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
            if (m_valid[i] && m_tag[i] == mtag(ID_pc)) begin
                if (ID_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = ID_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (ID_taken) begin
                m_valid[i] = 1; m_tag[i] = mtag(ID_pc); m_tgt[i] = ID_target; m_ctr[i] = 2;
            end
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        int  i;
        bit  hit;
        i   = midx(IF_pc);
        hit = m_valid[i] && (m_tag[i] == mtag(IF_pc));
        chk("model_pred_taken", {31'd0, pred_taken}, {31'd0, hit && (m_ctr[i] >= 2)});
        chk("model_pred_target", pred_target, hit ? m_tgt[i] : 32'd0);
        chk("model_mispredict", {31'd0, mispredict}, {31'd0, m_mis()});
        chk("model_br_count", {28'd0, br_count}, m_br);
        chk("model_miss_count", {28'd0, miss_count}, m_miss);
        if (ID_branch)
            chk("model_recover_pc", recover_pc, ID_taken ? ID_target : ID_pc + 32'd4);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- Directed stimulus ----------------
    initial begin
        rst = 1; stall = 0; IF_pc = 32'h40;
        ID_branch = 0; ID_pc = 0; ID_taken = 0; ID_target = 0;
        ID_pred_taken = 0; ID_pred_tgt = 0;

        // Reset state
        @(negedge clk);
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_br_count", {28'd0, br_count}, 32'd0);
        chk("rst_miss_count", {28'd0, miss_count}, 32'd0);
        cyc(); rst = 0;
        @(negedge clk);
        chk("cold_pred_taken", {31'd0, pred_taken}, 32'd0);

        // First taken branch allocates
        cyc(); ID_branch = 1; ID_pc = 32'h40; ID_taken = 1; ID_target = 32'h20;
        ID_pred_taken = 0; ID_pred_tgt = 0;
        @(negedge clk);
        chk("alloc_mispredict", {31'd0, mispredict}, 32'd1);
        chk("alloc_recover", recover_pc, 32'h20);
        cyc(); ID_branch = 0;
        @(negedge clk);
        chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("alloc_pred_target", pred_target, 32'h20);

        // Counter walk WT->WNT->SNT->WNT
        cyc(); ID_branch = 1; ID_taken = 0; ID_pred_taken = 1; ID_pred_tgt = 32'h20;
        @(negedge clk);
        chk("nt1_mispredict", {31'd0, mispredict}, 32'd1);
        chk("nt1_recover", recover_pc, 32'h44);
        cyc(); ID_branch = 0;
        @(negedge clk);
        chk("wnt_pred_taken", {31'd0, pred_taken}, 32'd0);
        cyc(); ID_branch = 1; ID_pred_taken = 0;
        @(negedge clk);
        chk("nt2_mispredict", {31'd0, mispredict}, 32'd0);
        chk("nt2_recover", recover_pc, 32'h44);
        cyc(); ID_branch = 0;
        @(negedge clk);
        chk("snt_pred_taken", {31'd0, pred_taken}, 32'd0);
        cyc(); ID_branch = 1; ID_taken = 1; ID_target = 32'h20; ID_pred_taken = 0;
        @(negedge clk);
        chk("t3_mispredict", {31'd0, mispredict}, 32'd1);
        cyc(); ID_branch = 0;
        @(negedge clk);
        chk("wnt2_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("walk_br_count", {28'd0, br_count}, 32'd4);
        chk("walk_miss_count", {28'd0, miss_count}, 32'd3);

        // Aliasing: 0x440 replaces 0x40
        cyc(); ID_branch = 1; ID_pc = 32'h440; ID_taken = 1; ID_target = 32'h100; ID_pred_taken = 0;
        @(negedge clk);
        chk("alias_mispredict", {31'd0, mispredict}, 32'd1);
        cyc(); ID_branch = 0;
        @(negedge clk);
        chk("alias_old_pred", {31'd0, pred_taken}, 32'd0);
        cyc(); IF_pc = 32'h440;
        @(negedge clk);
        chk("alias_new_pred", {31'd0, pred_taken}, 32'd1);
        chk("alias_new_target", pred_target, 32'h100);

        // Collision: lookup sees the pre-update entry
        cyc(); ID_branch = 1; ID_taken = 0; ID_pred_taken = 1; ID_pred_tgt = 32'h100;
        @(negedge clk);
        chk("collide_pred_old", {31'd0, pred_taken}, 32'd1);
        cyc(); ID_branch = 0;
        @(negedge clk);
        chk("collide_pred_new", {31'd0, pred_taken}, 32'd0);

        // Stall freezes training and mispredict
        cyc(); stall = 1; ID_branch = 1; ID_taken = 1; ID_target = 32'h100; ID_pred_taken = 0;
        @(negedge clk);
        chk("stall_mispredict", {31'd0, mispredict}, 32'd0);
        cyc();
        @(negedge clk);
        chk("stall_pred", {31'd0, pred_taken}, 32'd0);
        chk("stall_br_count", {28'd0, br_count}, 32'd6);
        chk("stall_miss_count", {28'd0, miss_count}, 32'd5);
        cyc(); stall = 0;
        @(negedge clk);
        chk("unstall_mispredict", {31'd0, mispredict}, 32'd1);
        cyc(); ID_branch = 0;
        @(negedge clk);
        chk("unstall_pred", {31'd0, pred_taken}, 32'd1);
        chk("unstall_br_count", {28'd0, br_count}, 32'd7);
        chk("unstall_miss_count", {28'd0, miss_count}, 32'd6);

        // Saturation of statistics
        cyc(); ID_branch = 1; ID_pc = 32'h80; ID_taken = 1; ID_target = 32'h200;
        ID_pred_taken = 0; ID_pred_tgt = 0; IF_pc = 32'h80;
        repeat (12) cyc();
        ID_branch = 0;
        @(negedge clk);
        chk("sat_miss_count", {28'd0, miss_count}, 32'd15);
        chk("sat_br_count", {28'd0, br_count}, 32'd15);
        chk("sat_pred", {31'd0, pred_taken}, 32'd1);

        // Reset mid-update
        cyc(); rst = 1; ID_branch = 1;
        @(negedge clk);
        chk("midrst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("midrst_pred_target", pred_target, 32'd0);
        chk("midrst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("midrst_br_count", {28'd0, br_count}, 32'd0);
        chk("midrst_miss_count", {28'd0, miss_count}, 32'd0);
        cyc(); rst = 0; ID_branch = 0;
        @(negedge clk);
        chk("postrst_pred", {31'd0, pred_taken}, 32'd0);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
